// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared encodings, FSM states and sizing helpers for the MAC neuron engine
package neuron_pkg;

    localparam logic [1:0] MODE_ID    = 2'b00;
    localparam logic [1:0] MODE_RELU  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_LEAKY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ACT   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Wide enough that bias<<FRAC plus (2^LEN_W-1)*P full products cannot overflow.
    function automatic int acc_width(input int n, input int len_w, input int p);
        return 2 * n + len_w + $clog2(p) + 1;
    endfunction

    function automatic longint sat_max(input int n);
        return (longint'(1) << (n - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) << (n - 1));
    endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// rtl/mac_lane_mult.sv - one signed NxN multiplier lane with a registered full-precision product
module mac_lane_mult #(
    parameter int N = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] prod_o
);

    logic signed [2*N-1:0] prod_q;
    logic signed [2*N-1:0] prod_d;

    assign prod_d = (2*N)'(a_i) * (2*N)'(b_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/mac_neuron_engine.sv
// rtl/mac_neuron_engine.sv - P-lane streaming MAC neuron with bias, activation and saturation
module mac_neuron_engine
    import neuron_pkg::*;
#(
    parameter int N     = 16,
    parameter int FRAC  = 8,
    parameter int P     = 4,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic [1:0]          mode,
    input  logic signed [N-1:0] bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [P*N-1:0]      x_in,
    input  logic [P*N-1:0]      w_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_data,
    output logic                sat_flag,
    output logic                busy
);

    localparam int ACCW = acc_width(N, LEN_W, P);
    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(sat_max(N));
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(sat_min(N));
    localparam logic signed [ACCW-1:0] ONE    = ACCW'(1) << FRAC;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       count_q, count_d;
    logic [1:0]             mode_q, mode_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   prod_vld_q, prod_vld_d;
    logic signed [N-1:0]    out_data_q, out_data_d;
    logic                   sat_q, sat_d;

    logic                   accept;
    logic signed [2*N-1:0]  prod [P];
    logic signed [ACCW-1:0] prod_sum;
    logic signed [ACCW-1:0] act_v, act_a, act_c;
    logic                   act_sat;

    assign accept = in_valid && (state_q == ST_RUN);

    for (genvar i = 0; i < P; i++) begin : g_lane
        mac_lane_mult #(.N(N)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (accept),
            .a_i    (x_in[i*N +: N]),
            .b_i    (w_in[i*N +: N]),
            .prod_o (prod[i])
        );
    end

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < P; i++) begin
            prod_sum = prod_sum + ACCW'(prod[i]);
        end
    end

    always_comb begin
        act_v = acc_q >>> FRAC;
        act_a = act_v;
        case (mode_q)
            MODE_ID:    act_a = act_v;
            MODE_RELU:  act_a = act_v[ACCW-1] ? '0 : act_v;
            MODE_STEP:  act_a = (!act_v[ACCW-1] && (act_v != '0)) ? ONE : '0;
            MODE_LEAKY: act_a = act_v[ACCW-1] ? (act_v >>> 3) : act_v;
            default:    act_a = act_v;
        endcase
        act_c   = act_a;
        act_sat = 1'b0;
        if (act_a > SAT_HI) begin
            act_c   = SAT_HI;
            act_sat = 1'b1;
        end else if (act_a < SAT_LO) begin
            act_c   = SAT_LO;
            act_sat = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        prod_vld_d = accept;

        // Products registered last edge are folded in while the next beat is accepted.
        if (prod_vld_q) begin
            acc_d = acc_q + prod_sum;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    count_d = len;
                    acc_d   = ACCW'(bias) <<< FRAC;
                    state_d = (len != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_ACT;
            ST_ACT: begin
                out_data_d = act_c[N-1:0];
                sat_d      = act_sat;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    sat_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mode_q     <= MODE_ID;
            acc_q      <= '0;
            prod_vld_q <= 1'b0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            prod_vld_q <= prod_vld_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule
